// File: rtl/adc_frame_tx.sv
// adc_frame_tx: sends each ADC sample as a framed UART packet.
// Frame is SYNC, sample high byte, sample low byte, XOR checksum, 8N1.
module adc_frame_tx #(
  parameter int unsigned CLK_DIV = 104,
  parameter logic [7:0]  SYNC    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic        din_valid,
  input  logic        clr_ovr,
  output logic        tx,
  output logic        busy,
  output logic        ovr
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_q;
  logic [1:0]  byte_q;
  logic [31:0] frame_q;
  logic [15:0] hold_q;
  logic        hold_vld_q;
  logic        tx_q;
  logic        busy_q;
  logic        ovr_q;
  logic        ovr_d;
  logic        ovr_set;
  logic        bit_end;
  logic [2:0]  nxt_bit;
  logic [7:0]  cur_byte;

  function automatic logic [31:0] mk_frame(input logic [15:0] s);
    return {SYNC, s[15:8], s[7:0], SYNC ^ s[15:8] ^ s[7:0]};
  endfunction

  assign bit_end = (cnt_q == DIV_M1);
  assign nxt_bit = bit_q + 3'd1;

  // Select the byte currently on the wire.
  always_comb begin
    cur_byte = frame_q[31:24];
    unique case (byte_q)
      2'd0: cur_byte = frame_q[31:24];
      2'd1: cur_byte = frame_q[23:16];
      2'd2: cur_byte = frame_q[15:8];
      2'd3: cur_byte = frame_q[7:0];
      default: cur_byte = frame_q[31:24];
    endcase
  end

  // Overrun: a strobe while the frame runs and the holding slot is full.
  always_comb begin
    ovr_set = din_valid && (state_q != IDLE) && hold_vld_q;
    ovr_d   = (ovr_q && !clr_ovr) || ovr_set;
  end

  // Frame FSM, bit timing, holding slot and registered line outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      frame_q    <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_q  <= '0;
          bit_q  <= '0;
          byte_q <= '0;
          if (hold_vld_q) begin
            frame_q    <= mk_frame(hold_q);
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= START;
            hold_vld_q <= din_valid;
            if (din_valid) hold_q <= din;
          end else if (din_valid) begin
            frame_q <= mk_frame(din);
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START;
          end else begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= cur_byte[0];
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q <= nxt_bit;
              tx_q  <= cur_byte[nxt_bit];
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (byte_q == 2'd3) begin
              byte_q  <= '0;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              byte_q  <= byte_q + 2'd1;
              tx_q    <= 1'b0;
              state_q <= START;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (state_q != IDLE && din_valid && !hold_vld_q) begin
        hold_q     <= din;
        hold_vld_q <= 1'b1;
      end
    end
  end

  // Sticky overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovr_q <= 1'b0;
    else     ovr_q <= ovr_d;
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign ovr  = ovr_q;

endmodule

// File: tb/tb_adc_frame_tx.sv
// tb_adc_frame_tx: directed bench for adc_frame_tx with CLK_DIV=4.
// A UART monitor decodes tx into bytes and start times.
module tb_adc_frame_tx;

  localparam int D = 4;

  logic        clk;
  logic        rst;
  logic [15:0] din;
  logic        din_valid;
  logic        clr_ovr;
  logic        tx;
  logic        busy;
  logic        ovr;

  int checks   = 0;
  int failures = 0;

  adc_frame_tx #(
    .CLK_DIV(D),
    .SYNC   (8'hA5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_valid(din_valid),
    .clr_ovr  (clr_ovr),
    .tx       (tx),
    .busy     (busy),
    .ovr      (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] rxq[$];
  int         rxt[$];
  int         cyc  = 0;
  bit         mact = 0;
  int         mpos = 0;
  int         mst  = 0;
  logic [7:0] msh  = 8'h00;

  // UART receiver: samples mid-bit on falling edges.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      mact = 0;
    end else if (!mact) begin
      if (tx === 1'b0) begin
        mact = 1;
        mpos = 0;
        mst  = cyc;
      end
    end else begin
      mpos = mpos + 1;
      if (mpos == 2) begin
        if (tx !== 1'b0) begin
          checks++;
          failures++;
          $display("FAIL start_bit: got %b required 0", tx);
          mact = 0;
        end
      end else if (mpos >= 6 && mpos <= 34 && ((mpos - 2) % 4) == 0) begin
        msh[(mpos - 6) / 4] = tx;
      end else if (mpos == 38) begin
        checks++;
        if (tx !== 1'b1) begin
          failures++;
          $display("FAIL stop_bit: got %b required 1", tx);
        end
        rxq.push_back(msh);
        rxt.push_back(mst);
        mact = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic strobe(input logic [15:0] d);
    din       = d;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic clear_rx();
    rxq.delete();
    rxt.delete();
  endtask

  task automatic wait_idle();
    int quiet = 0;
    for (int i = 0; i < 1000 && quiet < 3; i++) begin
      @(negedge clk);
      if (!busy && tx === 1'b1) quiet++;
      else quiet = 0;
    end
    chk("idle_timeout", quiet, 3);
  endtask

  task automatic wait_bytes(input int n);
    int i = 0;
    while (rxq.size() < n && i < 1000) begin
      @(negedge clk);
      i++;
    end
    chk("rx_count", rxq.size(), n);
  endtask

  task automatic chk_frame(input int base, input logic [31:0] exp,
                           input string nm);
    logic [7:0] a;
    logic [7:0] e;
    for (int i = 0; i < 4; i++) begin
      a = (rxq.size() > base + i) ? rxq[base + i] : 8'hxx;
      e = exp[31 - 8 * i -: 8];
      chk($sformatf("%s_b%0d", nm, i), {24'h0, a}, {24'h0, e});
    end
  endtask

  task automatic chk_gap(input string nm);
    int g;
    g = (rxt.size() >= 5) ? rxt[4] - rxt[0] : -1;
    chk(nm, g, 40 * D + 1);
  endtask

  typedef struct {
    logic [15:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[6];

  initial begin
    int n;

    vt[0] = '{16'h1234, 32'hA5123483};
    vt[1] = '{16'hABCD, 32'hA5ABCDC3};
    vt[2] = '{16'h00FF, 32'hA500FF5A};
    vt[3] = '{16'h0000, 32'hA50000A5};
    vt[4] = '{16'hFFFF, 32'hA5FFFFA5};
    vt[5] = '{16'h5AA5, 32'hA55AA55A};

    rst       = 1'b1;
    din       = 16'h0;
    din_valid = 1'b0;
    clr_ovr   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", ovr, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      clear_rx();
      strobe(vt[v].din);
      chk($sformatf("v%0d_tx_low", v), tx, 0);
      chk($sformatf("v%0d_busy", v), busy, 1);
      din = ~vt[v].din;
      n = 1;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (!busy) break;
        n++;
      end
      chk($sformatf("v%0d_busy_len", v), n, 40 * D);
      wait_bytes(4);
      chk_frame(0, vt[v].exp, $sformatf("v%0d", v));
      wait_idle();
    end

    clear_rx();
    strobe(16'h1234);
    repeat (19) @(negedge clk);
    strobe(16'h00FF);
    wait_bytes(8);
    chk_frame(0, 32'hA5123483, "b2b_f0");
    chk_frame(4, 32'hA500FF5A, "b2b_f1");
    chk_gap("b2b_gap");
    chk("b2b_ovr", ovr, 0);
    wait_idle();

    clear_rx();
    strobe(16'h1111);
    repeat (10) @(negedge clk);
    strobe(16'h2222);
    repeat (10) @(negedge clk);
    strobe(16'h3333);
    chk("ovr_set", ovr, 1);
    wait_bytes(8);
    repeat (250) @(negedge clk);
    chk("ovr_nframes", rxq.size(), 8);
    chk_frame(0, 32'hA51111A5, "ovr_f0");
    chk_frame(4, 32'hA52222A5, "ovr_f1");
    chk("ovr_sticky", ovr, 1);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    chk("ovr_clr", ovr, 0);
    wait_idle();

    clear_rx();
    strobe(16'h1234);
    repeat (50) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mrst_tx", tx, 1);
    chk("mrst_busy", busy, 0);
    @(negedge clk);
    din       = 16'h7E7E;
    din_valid = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    din_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ign_busy", busy, 0);
    chk("rst_ign_tx", tx, 1);
    clear_rx();
    strobe(16'hABCD);
    wait_bytes(4);
    chk_frame(0, 32'hA5ABCDC3, "mrst_f");
    wait_idle();

    clear_rx();
    strobe(16'h1234);
    repeat (159) @(negedge clk);
    din       = 16'h00FF;
    din_valid = 1'b1;
    chk("last_busy", busy, 1);
    @(negedge clk);
    din_valid = 1'b0;
    chk("gap_busy", busy, 0);
    chk("gap_tx", tx, 1);
    @(negedge clk);
    chk("next_tx_low", tx, 0);
    chk("next_busy", busy, 1);
    wait_bytes(8);
    chk_frame(4, 32'hA500FF5A, "last_f1");
    chk_gap("last_gap");
    wait_idle();

    clear_rx();
    strobe(16'h1234);
    repeat (10) @(negedge clk);
    strobe(16'h00FF);
    repeat (10) @(negedge clk);
    strobe(16'h5555);
    chk("co_ovr_pre", ovr, 1);
    repeat (137) @(negedge clk);
    din       = 16'h7777;
    din_valid = 1'b1;
    clr_ovr   = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    clr_ovr   = 1'b0;
    chk("co_ovr_keep", ovr, 1);
    wait_bytes(8);
    repeat (250) @(negedge clk);
    chk("co_nframes", rxq.size(), 8);
    chk_frame(0, 32'hA5123483, "co_f0");
    chk_frame(4, 32'hA500FF5A, "co_f1");
    chk_gap("co_gap");
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    chk("co_ovr_clr", ovr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
